// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed N-digit seven-segment driver. Holds a latched copy of the
// packed digit word, steps through one digit per scan slot, decodes it to the
// {g,f,e,d,c,b,a} segment pattern and drives the matching one-hot digit enable.
// Leading-zero suppression and a global blank act on the decoded values just
// before the output register. Output polarity is applied at the very last step.

module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

    // XOR masks for output polarity: they are also the "all inactive" levels.
    localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW != 0}};

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] value_q;

    logic [3:0]              cur_code;
    logic                    cur_lz;
    logic                    zero_above;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    slot_end;

    // Active-high segment patterns; codes 10-15 only light up in hex mode.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h67;
            4'hA:    pattern = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'hB:    pattern = (HEX_MODE != 0) ? 7'h7C : 7'h00;
            4'hC:    pattern = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'hD:    pattern = (HEX_MODE != 0) ? 7'h5E : 7'h00;
            4'hE:    pattern = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            default: pattern = (HEX_MODE != 0) ? 7'h71 : 7'h00;
        endcase
        return pattern;
    endfunction

    assign slot_end = (div_cnt == LAST_DIV);

    // Select the scanned digit, work out leading-zero suppression from the top digit down, and build the next seg/an values.
    always_comb begin
        cur_code   = 4'h0;
        cur_lz     = 1'b0;
        zero_above = 1'b1;
        an_next    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (value_q[4*k +: 4] == 4'h0);
            an_next[k] = (idx == IDX_W'(k));
            if (idx == IDX_W'(k)) begin
                cur_code = value_q[4*k +: 4];
                cur_lz   = lz_blank && (k > 0) && zero_above;
            end
        end
        seg_next = cur_lz ? 7'h00 : decode(cur_code);
        if (blank) begin
            seg_next = 7'h00;
            an_next  = '0;
        end
    end

    // Prescaler, digit index, frame pulse, value latch and the polarity-adjusted output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            value_q <= '0;
            frame   <= 1'b0;
            seg     <= SEG_OFF;
            an      <= AN_OFF;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                if (idx == LAST_IDX) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            frame <= slot_end && (idx == LAST_IDX);
            if (load) begin
                value_q <= value;
            end
            seg <= seg_next ^ SEG_OFF;
            an  <= an_next ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for the seven-segment scan driver. Four instances share the
// same inputs: decimal active-high (main), hex active-high, decimal active-low,
// and a one-cycle-per-slot variant. Expected patterns are written out by hand.

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        blank;
    logic        lz_blank;
    logic [15:0] value;

    logic [6:0]  seg0, seg1, seg2, seg3;
    logic [3:0]  an0, an1, an2, an3;
    logic        frame0, frame1, frame2, frame3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(0)) dut_dec (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .lz_blank(lz_blank), .seg(seg0), .an(an0), .frame(frame0)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .ACTIVE_LOW(0)) dut_hex (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .lz_blank(lz_blank), .seg(seg1), .an(an1), .frame(frame1)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .ACTIVE_LOW(1)) dut_low (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .lz_blank(lz_blank), .seg(seg2), .an(an2), .frame(frame2)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(1), .HEX_MODE(0), .ACTIVE_LOW(0)) dut_fast (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank(blank),
        .lz_blank(lz_blank), .seg(seg3), .an(an3), .frame(frame3)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a new word with a one-cycle load strobe.
    task automatic applyStimulus(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Advance until the main instance shows a frame pulse, bounded.
    task automatic waitFrame();
        int n;
        n = 0;
        tick();
        while (frame0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("frame_sync", frame0, 1);
    endtask

    // Starting on a frame (or reset) cycle, follow one full 16-cycle scan.
    // exp_dec/exp_hex pack the digit patterns as {d3,d2,d1,d0}.
    task automatic checkScan(input string tag, input logic [27:0] exp_dec, input logic [27:0] exp_hex);
        for (int i = 1; i <= 16; i++) begin
            int         d;
            logic [3:0] exp_an;
            logic [3:0] exp_an_low;
            logic [6:0] exp_seg;
            logic [6:0] exp_seg_hex;
            logic [6:0] exp_seg_low;
            tick();
            d           = (i - 1) / 4;
            exp_an      = 4'b0001 << d;
            exp_an_low  = ~exp_an;
            exp_seg     = exp_dec[7*d +: 7];
            exp_seg_hex = exp_hex[7*d +: 7];
            exp_seg_low = ~exp_seg;
            checkOutput($sformatf("%s_seg_c%0d", tag, i), seg0, exp_seg);
            checkOutput($sformatf("%s_an_c%0d", tag, i), an0, exp_an);
            checkOutput($sformatf("%s_frame_c%0d", tag, i), frame0, (i == 16));
            checkOutput($sformatf("%s_hexseg_c%0d", tag, i), seg1, exp_seg_hex);
            checkOutput($sformatf("%s_lowseg_c%0d", tag, i), seg2, exp_seg_low);
            checkOutput($sformatf("%s_lowan_c%0d", tag, i), an2, exp_an_low);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [27:0] fast_exp;
        int          n;

        reset    = 1'b1;
        load     = 1'b0;
        blank    = 1'b0;
        lz_blank = 1'b0;
        value    = 16'h0000;

        // Reset state on every polarity.
        tick();
        tick();
        checkOutput("rst_seg", seg0, 7'h00);
        checkOutput("rst_an", an0, 4'h0);
        checkOutput("rst_frame", frame0, 0);
        checkOutput("rst_low_seg", seg2, 7'h7F);
        checkOutput("rst_low_an", an2, 4'hF);

        // First cycle out of reset shows digit 0 of the cleared word.
        reset = 1'b0;
        tick();
        checkOutput("post_rst_seg", seg0, 7'h3F);
        checkOutput("post_rst_an", an0, 4'b0001);

        // Basic scan of 1234.
        applyStimulus(16'h1234);
        waitFrame();
        checkScan("t1_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66});

        // One-cycle slots: a new digit each cycle, frame every 4 cycles.
        n = 0;
        while (frame3 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("fast_sync", frame3, 1);
        fast_exp = {7'h06, 7'h5B, 7'h4F, 7'h66};
        for (int i = 0; i < 4; i++) begin
            logic [6:0] e;
            logic [3:0] a;
            tick();
            e = fast_exp[7*i +: 7];
            a = 4'b0001 << i;
            checkOutput($sformatf("fast_seg_%0d", i), seg3, e);
            checkOutput($sformatf("fast_an_%0d", i), an3, a);
            checkOutput($sformatf("fast_frame_%0d", i), frame3, (i == 3));
        end

        // Leading-zero suppression.
        lz_blank = 1'b1;
        applyStimulus(16'h0070);
        waitFrame();
        checkScan("t2_0070_lz", {7'h00, 7'h00, 7'h07, 7'h3F}, {7'h00, 7'h00, 7'h07, 7'h3F});
        applyStimulus(16'h0000);
        waitFrame();
        checkScan("t2_0000_lz", {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F});
        applyStimulus(16'h1000);
        waitFrame();
        checkScan("t2_1000_lz", {7'h06, 7'h3F, 7'h3F, 7'h3F}, {7'h06, 7'h3F, 7'h3F, 7'h3F});
        lz_blank = 1'b0;
        applyStimulus(16'h0070);
        waitFrame();
        checkScan("t2_0070_nolz", {7'h3F, 7'h3F, 7'h07, 7'h3F}, {7'h3F, 7'h3F, 7'h07, 7'h3F});

        // Codes 10-15: blank in decimal mode, letters in hex mode.
        applyStimulus(16'hABCD);
        waitFrame();
        checkScan("t3_abcd", 28'h0, {7'h77, 7'h7C, 7'h39, 7'h5E});

        // All segments lit; active-low copy shows all zeros.
        applyStimulus(16'h8888);
        waitFrame();
        checkScan("t5_8888", {4{7'h7F}}, {4{7'h7F}});

        // Global blank for 10 cycles starting mid-slot.
        applyStimulus(16'h1234);
        waitFrame();
        tick();
        tick();
        blank = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checkOutput($sformatf("t4_blank_seg_%0d", i), seg0, 7'h00);
            checkOutput($sformatf("t4_blank_an_%0d", i), an0, 4'h0);
            checkOutput($sformatf("t4_blank_frame_%0d", i), frame0, 0);
            checkOutput($sformatf("t4_blank_lowseg_%0d", i), seg2, 7'h7F);
            checkOutput($sformatf("t4_blank_lowan_%0d", i), an2, 4'hF);
        end
        blank = 1'b0;
        for (int t = 13; t <= 16; t++) begin
            tick();
            checkOutput($sformatf("t4_resume_seg_%0d", t), seg0, 7'h06);
            checkOutput($sformatf("t4_resume_an_%0d", t), an0, 4'b1000);
            checkOutput($sformatf("t4_resume_frame_%0d", t), frame0, (t == 16));
        end

        // Load coinciding with a slot advance (now on a frame cycle, div_cnt=0).
        tick();
        tick();
        tick();
        value = 16'h5678;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        checkOutput("t5_load_old_seg", seg0, 7'h66);
        checkOutput("t5_load_old_an", an0, 4'b0001);
        tick();
        checkOutput("t5_load_new_seg", seg0, 7'h07);
        checkOutput("t5_load_new_an", an0, 4'b0010);

        // Reset in the middle of digit 2.
        applyStimulus(16'h1234);
        waitFrame();
        for (int i = 1; i <= 10; i++) begin
            tick();
        end
        checkOutput("t6_pre_seg", seg0, 7'h5B);
        checkOutput("t6_pre_an", an0, 4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t6_rst_seg", seg0, 7'h00);
        checkOutput("t6_rst_an", an0, 4'h0);
        checkOutput("t6_rst_frame", frame0, 0);
        checkOutput("t6_rst_lowseg", seg2, 7'h7F);
        checkOutput("t6_rst_lowan", an2, 4'hF);
        checkScan("t6_after_rst", {4{7'h3F}}, {4{7'h3F}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
